// File: rtl/pram_arb_pkg.sv
// Shared definitions for the program-RAM arbiter: port indices, FSM states
// and small index/one-hot conversion helpers.
package pram_arb_pkg;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] PORT_SUB  = 2'd0;
  localparam logic [1:0] PORT_MAIN = 2'd1;
  localparam logic [1:0] PORT_DMA  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DATA  = 2'd2
  } state_e;

  // One-hot grant vector to port index; an illegal vector maps to the sub CPU.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b001:  idx = PORT_SUB;
      3'b010:  idx = PORT_MAIN;
      3'b100:  idx = PORT_DMA;
      default: idx = PORT_SUB;
    endcase
    return idx;
  endfunction

  // Port index to one-hot; an out-of-range index yields no bit set.
  function automatic logic [NUM_PORTS-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [NUM_PORTS-1:0] oh;
    case (idx)
      PORT_SUB:  oh = 3'b001;
      PORT_MAIN: oh = 3'b010;
      PORT_DMA:  oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/pram_arb_if.sv
// Bundle of requester handshakes and RAM-side signals around the arbiter.
// slave: the arbiter itself. master: the requesters plus the RAM.
interface pram_arb_if;
  logic        req_sub,  req_main,  req_dma;
  logic        we_sub,   we_main,   we_dma;
  logic [15:0] addr_sub, addr_main, addr_dma;
  logic [7:0]  din_sub,  din_main,  din_dma;
  logic        ack_sub,  ack_main,  ack_dma;
  logic [7:0]  dout_sub, dout_main, dout_dma;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        busy;

  modport slave (
    input  req_sub, req_main, req_dma,
    input  we_sub, we_main, we_dma,
    input  addr_sub, addr_main, addr_dma,
    input  din_sub, din_main, din_dma,
    input  ram_dout,
    output ack_sub, ack_main, ack_dma,
    output dout_sub, dout_main, dout_dma,
    output ram_addr, ram_din, ram_we,
    output busy
  );

  modport master (
    output req_sub, req_main, req_dma,
    output we_sub, we_main, we_dma,
    output addr_sub, addr_main, addr_dma,
    output din_sub, din_main, din_dma,
    output ram_dout,
    input  ack_sub, ack_main, ack_dma,
    input  dout_sub, dout_main, dout_dma,
    input  ram_addr, ram_din, ram_we,
    input  busy
  );
endinterface

// File: rtl/pram_arb_rr_pick3.sv
// Combinational 3-way round-robin selector. The search starts at the port
// after the last-granted pointer and wraps; the first requester found wins.
module rr_pick3
  import pram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [1:0]           ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 valid_o
);

  // Priority search in the order ptr+1, ptr+2, ptr+3 (mod 3).
  always_comb begin
    gnt_o = 3'b000;
    case (ptr_i)
      PORT_SUB: begin
        if (req_i[1])      gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else               gnt_o = 3'b000;
      end
      PORT_MAIN: begin
        if (req_i[2])      gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else               gnt_o = 3'b000;
      end
      default: begin
        // ptr = DMA (and the unused encoding) searches sub, main, dma.
        if (req_i[0])      gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else               gnt_o = 3'b000;
      end
    endcase
    valid_o = |req_i;
  end

endmodule

// File: rtl/pram_arb.sv
// Arbiter/sequencer for a shared single-port 64K x 8 RAM with a registered
// read. Each access walks IDLE -> GRANT -> DATA; all state moves on the
// falling clock edge and only while ce is high.
module pram_arb
  import pram_arb_pkg::*;
#(
  parameter int unsigned DMA_BURST    = 4,
  parameter int unsigned RR_RESET_PTR = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  pram_arb_if.slave  bus
);

  localparam logic [3:0] BURST_MAX = 4'(DMA_BURST);
  localparam logic [1:0] PTR_RST   = 2'(RR_RESET_PTR);

  state_e                     state_q, state_d;
  logic [1:0]                 ptr_q, ptr_d;
  logic [3:0]                 burst_q, burst_d;
  logic [1:0]                 winner_q, winner_d;
  logic                       is_wr_q, is_wr_d;
  logic [15:0]                ram_addr_q, ram_addr_d;
  logic [7:0]                 ram_din_q, ram_din_d;
  logic                       ram_we_q, ram_we_d;
  logic [NUM_PORTS-1:0]       ack_q, ack_d;
  logic [NUM_PORTS-1:0][7:0]  dout_q, dout_d;
  logic                       busy_q, busy_d;

  logic [NUM_PORTS-1:0]       req_vec_s;
  logic [NUM_PORTS-1:0]       req_mask_s;
  logic [NUM_PORTS-1:0]       gnt_s;
  logic                       gnt_valid_s;
  logic                       dma_block_s;
  logic [1:0]                 win_idx_s;
  logic                       sel_we_s;
  logic [15:0]                sel_addr_s;
  logic [7:0]                 sel_din_s;

  // DMA is masked out once its burst is used up and a CPU is waiting.
  always_comb begin
    req_vec_s   = {bus.req_dma, bus.req_main, bus.req_sub};
    dma_block_s = (burst_q == BURST_MAX) && (bus.req_sub || bus.req_main);
    req_mask_s  = req_vec_s & {~dma_block_s, 2'b11};
  end

  rr_pick3 u_pick (
    .req_i   (req_mask_s),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt_s),
    .valid_o (gnt_valid_s)
  );

  // Route the winning requester's command fields.
  always_comb begin
    win_idx_s = onehot_to_idx(gnt_s);
    case (win_idx_s)
      PORT_MAIN: begin
        sel_we_s = bus.we_main; sel_addr_s = bus.addr_main; sel_din_s = bus.din_main;
      end
      PORT_DMA: begin
        sel_we_s = bus.we_dma;  sel_addr_s = bus.addr_dma;  sel_din_s = bus.din_dma;
      end
      default: begin
        sel_we_s = bus.we_sub;  sel_addr_s = bus.addr_sub;  sel_din_s = bus.din_sub;
      end
    endcase
  end

  // Next-state and output logic; ack and ram_we default low so each pulses once.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    winner_d   = winner_q;
    is_wr_d    = is_wr_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    ack_d      = 3'b000;
    dout_d     = dout_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          ram_addr_d = sel_addr_s;
          ram_din_d  = sel_din_s;
          ram_we_d   = sel_we_s;
          is_wr_d    = sel_we_s;
          winner_d   = win_idx_s;
          if (win_idx_s == PORT_DMA) begin
            burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 4'd1;
          end else begin
            burst_d = 4'd0;
          end
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        state_d = DATA;
      end
      DATA: begin
        ack_d = idx_to_onehot(winner_q);
        if (!is_wr_q) begin
          case (winner_q)
            PORT_SUB:  dout_d[0] = bus.ram_dout;
            PORT_MAIN: dout_d[1] = bus.ram_dout;
            PORT_DMA:  dout_d[2] = bus.ram_dout;
            default:   dout_d    = dout_q;
          endcase
        end else begin
          dout_d = dout_q;
        end
        ptr_d   = winner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State register: synchronous reset, otherwise advance only on enabled cycles.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_RST;
      burst_q    <= 4'd0;
      winner_q   <= PORT_SUB;
      is_wr_q    <= 1'b0;
      ram_addr_q <= 16'h0000;
      ram_din_q  <= 8'h00;
      ram_we_q   <= 1'b0;
      ack_q      <= 3'b000;
      dout_q     <= '0;
      busy_q     <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      winner_q   <= winner_d;
      is_wr_q    <= is_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ack_sub   = ack_q[0];
  assign bus.ack_main  = ack_q[1];
  assign bus.ack_dma   = ack_q[2];
  assign bus.dout_sub  = dout_q[0];
  assign bus.dout_main = dout_q[1];
  assign bus.dout_dma  = dout_q[2];
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pram_arb.sv
// Directed bench for pram_arb: a per-cycle vector table for the basic
// read/write/round-robin flow, plus hand-written burst, reset and ce sequences.
module tb_pram_arb;

  logic clk, rst, ce;
  pram_arb_if bus();

  pram_arb #(.DMA_BURST(4), .RR_RESET_PTR(2)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  mem [0:65535];
  logic        pre_en;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  typedef struct {
    logic        rst;
    logic [2:0]  req;     // {dma, main, sub}
    logic [2:0]  we;
    logic [2:0]  ack;
    logic        busy;
    logic        ram_we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  d_sub;
    logic [7:0]  d_main;
    logic [7:0]  d_dma;
  } vec_t;

  vec_t tbl [31];

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // RAM model: falling-edge, registered read, enabled by ce; backdoor preload.
  always @(negedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (ce) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ack_vec();
    return {bus.ack_dma, bus.ack_main, bus.ack_sub};
  endfunction

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  // Steps until the given port acks; cyc = -1 if the budget runs out.
  task automatic wait_ack(input int port, input int max_c, output int cyc);
    logic [2:0] a;
    logic       done;
    cyc  = -1;
    done = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      if (!done) begin
        step();
        a = ack_vec();
        if (a[port]) begin
          cyc  = c;
          done = 1'b1;
        end
      end
    end
  endtask

  // Main-CPU access with ce toggling every clock, starting with ce low.
  task automatic ce_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] exp_dout, input int exp_we, input string nm);
    logic [12:0] hist;
    int          wecnt;
    logic        seen;
    hist  = '0;
    wecnt = 0;
    seen  = 1'b0;
    bus.we_main = wr; bus.addr_main = a; bus.din_main = d;
    for (int k = 1; k <= 12; k++) begin
      ce = (k % 2 == 0);
      bus.req_main = !seen;
      if (ce && bus.ram_we) wecnt++;
      step();
      hist[k] = bus.ack_main;
      if (bus.ack_main) seen = 1'b1;
    end
    ce = 1'b1;
    bus.req_main = 1'b0;
    chk({nm, " ack timing"}, 32'(hist), 32'h0C0);
    chk({nm, " ram_we enabled cycles"}, 32'(wecnt), 32'(exp_we));
    chk({nm, " dout_main"}, 32'(bus.dout_main), 32'(exp_dout));
  endtask

  initial begin
    int cyc;

    rst = 1'b1; ce = 1'b1; pre_en = 1'b0; pre_addr = 16'h0000; pre_data = 8'h00;
    bus.req_sub = 1'b0; bus.req_main = 1'b0; bus.req_dma = 1'b0;
    bus.we_sub = 1'b0;  bus.we_main = 1'b0;  bus.we_dma = 1'b0;
    bus.addr_sub = 16'h1234; bus.addr_main = 16'hFFFF; bus.addr_dma = 16'h0ABC;
    bus.din_sub = 8'h11;     bus.din_main = 8'hC3;     bus.din_dma = 8'h22;
    bus.ram_dout = 8'h00;

    preload(16'h0000, 8'h00);
    preload(16'h1234, 8'h5A);
    preload(16'h0ABC, 8'h77);
    preload(16'hFFFF, 8'h00);
    step();

    // Reset state
    chk("reset ack", 32'(ack_vec()), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset ram_we", 32'(bus.ram_we), 32'h0);
    chk("reset ram_addr", 32'(bus.ram_addr), 32'h0);
    chk("reset ram_din", 32'(bus.ram_din), 32'h0);
    chk("reset dout", {8'h00, bus.dout_dma, bus.dout_main, bus.dout_sub}, 32'h0);
    rst = 1'b0;

    // rst, req, we, ack, busy, ram_we, addr, din, d_sub, d_main, d_dma
    // Single read by sub
    tbl[0]  = '{1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 16'h1234, 8'h11, 8'h00, 8'h00, 8'h00};
    tbl[1]  = tbl[0];
    tbl[2]  = '{1'b0, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 16'h1234, 8'h11, 8'h5A, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h1234, 8'h11, 8'h5A, 8'h00, 8'h00};
    // Main writes 0xC3 to 0xFFFF, then reads it back
    tbl[4]  = '{1'b0, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 16'hFFFF, 8'hC3, 8'h5A, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 3'b010, 3'b010, 3'b000, 1'b1, 1'b0, 16'hFFFF, 8'hC3, 8'h5A, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 16'hFFFF, 8'hC3, 8'h5A, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b0, 16'hFFFF, 8'hC3, 8'h5A, 8'h00, 8'h00};
    tbl[8]  = tbl[7];
    tbl[9]  = '{1'b0, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 16'hFFFF, 8'hC3, 8'h5A, 8'hC3, 8'h00};
    // Reset from IDLE, then all three request continuously
    tbl[10] = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[12] = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 16'h1234, 8'h11, 8'h00, 8'h00, 8'h00};
    tbl[13] = tbl[12];
    tbl[14] = '{1'b0, 3'b111, 3'b000, 3'b001, 1'b0, 1'b0, 16'h1234, 8'h11, 8'h5A, 8'h00, 8'h00};
    tbl[15] = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 16'hFFFF, 8'hC3, 8'h5A, 8'h00, 8'h00};
    tbl[16] = tbl[15];
    tbl[17] = '{1'b0, 3'b111, 3'b000, 3'b010, 1'b0, 1'b0, 16'hFFFF, 8'hC3, 8'h5A, 8'hC3, 8'h00};
    tbl[18] = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 16'h0ABC, 8'h22, 8'h5A, 8'hC3, 8'h00};
    tbl[19] = tbl[18];
    tbl[20] = '{1'b0, 3'b111, 3'b000, 3'b100, 1'b0, 1'b0, 16'h0ABC, 8'h22, 8'h5A, 8'hC3, 8'h77};
    tbl[21] = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 16'h1234, 8'h11, 8'h5A, 8'hC3, 8'h77};
    tbl[22] = tbl[21];
    tbl[23] = '{1'b0, 3'b111, 3'b000, 3'b001, 1'b0, 1'b0, 16'h1234, 8'h11, 8'h5A, 8'hC3, 8'h77};
    tbl[24] = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 16'hFFFF, 8'hC3, 8'h5A, 8'hC3, 8'h77};
    tbl[25] = tbl[24];
    tbl[26] = '{1'b0, 3'b111, 3'b000, 3'b010, 1'b0, 1'b0, 16'hFFFF, 8'hC3, 8'h5A, 8'hC3, 8'h77};
    tbl[27] = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 16'h0ABC, 8'h22, 8'h5A, 8'hC3, 8'h77};
    tbl[28] = tbl[27];
    tbl[29] = '{1'b0, 3'b111, 3'b000, 3'b100, 1'b0, 1'b0, 16'h0ABC, 8'h22, 8'h5A, 8'hC3, 8'h77};
    tbl[30] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0ABC, 8'h22, 8'h5A, 8'hC3, 8'h77};

    for (int i = 0; i < 31; i++) begin
      rst = tbl[i].rst;
      bus.req_sub = tbl[i].req[0]; bus.req_main = tbl[i].req[1]; bus.req_dma = tbl[i].req[2];
      bus.we_sub  = tbl[i].we[0];  bus.we_main  = tbl[i].we[1];  bus.we_dma  = tbl[i].we[2];
      step();
      chk($sformatf("row%0d ack", i), 32'(ack_vec()), 32'(tbl[i].ack));
      chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d ram_we", i), 32'(bus.ram_we), 32'(tbl[i].ram_we));
      chk($sformatf("row%0d ram_addr", i), 32'(bus.ram_addr), 32'(tbl[i].addr));
      chk($sformatf("row%0d ram_din", i), 32'(bus.ram_din), 32'(tbl[i].din));
      chk($sformatf("row%0d dout", i), {8'h00, bus.dout_dma, bus.dout_main, bus.dout_sub},
          {8'h00, tbl[i].d_dma, tbl[i].d_main, tbl[i].d_sub});
    end
    rst = 1'b0;

    // DMA burst: four DMA grants, then a waiting sub CPU must win
    rst = 1'b1; step(); rst = 1'b0;
    bus.req_dma = 1'b1;
    for (int g = 1; g <= 4; g++) begin
      wait_ack(2, 6, cyc);
      chk($sformatf("burst dma ack %0d latency", g), 32'(cyc), 32'd3);
    end
    bus.req_sub = 1'b1;
    step();
    chk("burst sub wins 5th grant", 32'(bus.ram_addr), 32'h1234);
    wait_ack(0, 6, cyc);
    chk("burst sub ack latency", 32'(cyc), 32'd2);
    bus.req_sub = 1'b0;
    for (int g = 1; g <= 6; g++) begin
      wait_ack(2, 6, cyc);
      chk($sformatf("dma alone ack %0d latency", g), 32'(cyc), 32'd3);
    end
    chk("dma alone dout", 32'(bus.dout_dma), 32'h77);
    bus.req_dma = 1'b0;
    step();

    // Main access so the pointer is not already at DMA, then reset in GRANT
    bus.req_main = 1'b1; bus.we_main = 1'b0;
    wait_ack(1, 6, cyc);
    chk("pre-reset main ack latency", 32'(cyc), 32'd3);
    bus.req_main = 1'b0;
    bus.req_sub = 1'b1; bus.we_sub = 1'b1; bus.addr_sub = 16'h5555; bus.din_sub = 8'h99;
    step();
    chk("grant write ram_we", 32'(bus.ram_we), 32'h1);
    rst = 1'b1;
    step();
    chk("rst in grant ram_we", 32'(bus.ram_we), 32'h0);
    chk("rst in grant ack", 32'(ack_vec()), 32'h0);
    chk("rst in grant busy", 32'(bus.busy), 32'h0);
    chk("rst in grant dout", {8'h00, bus.dout_dma, bus.dout_main, bus.dout_sub}, 32'h0);
    rst = 1'b0;
    bus.req_sub = 1'b0; bus.we_sub = 1'b0; bus.addr_sub = 16'h1234; bus.din_sub = 8'h11;
    step();
    chk("no ack after reset", 32'(ack_vec()), 32'h0);
    bus.req_sub = 1'b1; bus.req_main = 1'b1; bus.req_dma = 1'b1;
    step();
    chk("post-reset sub wins first", 32'(bus.ram_addr), 32'h1234);
    wait_ack(0, 6, cyc);
    chk("post-reset sub ack latency", 32'(cyc), 32'd2);
    bus.req_sub = 1'b0; bus.req_main = 1'b0; bus.req_dma = 1'b0;
    step();
    step();

    // ce toggling: write then read back through the main port
    ce_access(1'b1, 16'h4321, 8'h6E, 8'h00, 1, "ce write");
    ce_access(1'b0, 16'h4321, 8'h00, 8'h6E, 0, "ce read");

    // A request that drops while ce is low is never served
    ce = 1'b0; bus.req_sub = 1'b1;
    step();
    bus.req_sub = 1'b0; ce = 1'b1;
    step();
    chk("dropped req busy", 32'(bus.busy), 32'h0);
    step();
    chk("dropped req ack", 32'(ack_vec()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
